// File: rtl/fruit_classify_if.sv
// Frame-level bus between the per-colour area counters, the fruit classifier
// and whatever consumes its debounced decision.
interface fruit_classify_if;
  logic          en;
  logic          i_vs;
  logic [263:0]  i_area;
  logic [3:0]    o_class;
  logic [23:0]   o_area;
  logic [3:0]    o_cand;
  logic          o_valid;
  logic          o_busy;

  modport slave (
    input  en, i_vs, i_area,
    output o_class, o_area, o_cand, o_valid, o_busy
  );

  modport master (
    output en, i_vs, i_area,
    input  o_class, o_area, o_cand, o_valid, o_busy
  );
endinterface

// File: rtl/fruit_classify.sv
// Picks the colour class with the largest pixel area at each frame end and
// debounces that pick over STABLE_N consecutive frames before publishing it.
module fruit_classify #(
  parameter logic [23:0] AREA_MIN = 24'd2000,
  parameter int          STABLE_N = 3
) (
  input  logic          pixelclk,
  input  logic          rst_n,
  fruit_classify_if.slave bus
);

  localparam int CW = $clog2(STABLE_N + 1);

  typedef enum logic [2:0] {IDLE, SNAP, SCAN, DECIDE, UPDATE} state_t;

  state_t         state_reg, state_next;
  logic           vs_reg, vs_d_reg, armed_reg;
  logic           frame_end;
  logic [263:0]   snap_reg;
  logic [23:0]    max_reg;
  logic [3:0]     idx_reg, k_reg, cand_reg;
  logic [3:0]     prev_cand_reg, o_cand_reg, o_class_reg;
  logic [23:0]    o_area_reg;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           o_valid_reg;
  logic           busy, do_snap, do_scan, do_decide, do_update;
  logic [3:0]     cand_next;
  logic [23:0]    cur_area;
  logic [23:0]    area_arr [0:15];

  // armed stays low until i_vs has been seen low, so a sync already high at
  // reset release is not mistaken for a frame end
  assign frame_end = vs_reg & ~vs_d_reg & armed_reg;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_reg    <= 1'b0;
      vs_d_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      vs_reg    <= bus.i_vs;
      vs_d_reg  <= vs_reg;
      armed_reg <= armed_reg | ~bus.i_vs;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_area
      if (gi >= 1 && gi <= 11) begin : g_cls
        assign area_arr[gi] = snap_reg[24*gi-1 -: 24];
      end else begin : g_none
        assign area_arr[gi] = '0;
      end
    end
  endgenerate

  assign cur_area = area_arr[k_reg];

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_end && bus.en) state_next = SNAP;
      SNAP:    state_next = SCAN;
      SCAN:    if (k_reg == 4'd11) state_next = DECIDE;
      DECIDE:  state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    do_snap   = (state_reg == SNAP);
    do_scan   = (state_reg == SCAN);
    do_decide = (state_reg == DECIDE);
    do_update = (state_reg == UPDATE);
  end

  always_comb begin
    cand_next = (max_reg >= AREA_MIN) ? idx_reg : 4'd0;
    if (cand_reg == prev_cand_reg)
      cnt_next = (cnt_reg == CW'(STABLE_N)) ? cnt_reg : cnt_reg + CW'(1);
    else
      cnt_next = CW'(1);
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      snap_reg      <= '0;
      max_reg       <= '0;
      idx_reg       <= '0;
      k_reg         <= '0;
      cand_reg      <= '0;
      prev_cand_reg <= '0;
      cnt_reg       <= '0;
      o_cand_reg    <= '0;
      o_class_reg   <= '0;
      o_area_reg    <= '0;
      o_valid_reg   <= 1'b0;
    end else begin
      o_valid_reg <= do_update;
      if (do_snap) begin
        snap_reg <= bus.i_area;
        max_reg  <= '0;
        idx_reg  <= '0;
        k_reg    <= 4'd1;
      end
      if (do_scan) begin
        // strict compare keeps the lower class index on ties
        if (cur_area > max_reg) begin
          max_reg <= cur_area;
          idx_reg <= k_reg;
        end
        k_reg <= k_reg + 4'd1;
      end
      if (do_decide) begin
        cand_reg   <= cand_next;
        o_area_reg <= (cand_next != 4'd0) ? max_reg : 24'd0;
      end
      if (do_update) begin
        o_cand_reg    <= cand_reg;
        prev_cand_reg <= cand_reg;
        cnt_reg       <= cnt_next;
        if (cnt_next == CW'(STABLE_N)) o_class_reg <= cand_reg;
      end
    end
  end

  assign bus.o_class = o_class_reg;
  assign bus.o_area  = o_area_reg;
  assign bus.o_cand  = o_cand_reg;
  assign bus.o_valid = o_valid_reg;
  assign bus.o_busy  = busy;

endmodule

// File: tb/tb_fruit_classify.sv
// Drives two classifiers (STABLE_N=1 and STABLE_N=3) from the same frames and
// compares them with a frame-level model of the classification rules.
module tb_fruit_classify;

  localparam logic [23:0] AREA_MIN = 24'd2000;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          vs;
  logic [263:0]  area_bus;

  int checks   = 0;
  int failures = 0;

  logic [23:0] areas [1:11];
  int          hist[$];
  logic [3:0]  cls1_m, cls3_m;

  fruit_classify_if bus1 ();
  fruit_classify_if bus3 ();

  assign bus1.en = en;
  assign bus1.i_vs = vs;
  assign bus1.i_area = area_bus;
  assign bus3.en = en;
  assign bus3.i_vs = vs;
  assign bus3.i_area = area_bus;

  fruit_classify #(.AREA_MIN(AREA_MIN), .STABLE_N(1)) dut1 (
    .pixelclk (clk),
    .rst_n    (rst_n),
    .bus      (bus1)
  );

  fruit_classify #(.AREA_MIN(AREA_MIN), .STABLE_N(3)) dut3 (
    .pixelclk (clk),
    .rst_n    (rst_n),
    .bus      (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pack_areas();
    for (int k = 1; k <= 11; k++) area_bus[24*(k-1) +: 24] = areas[k];
  endtask

  task automatic set_all(input logic [23:0] v);
    for (int k = 1; k <= 11; k++) areas[k] = v;
  endtask

  // o_class takes a candidate once the last n candidates all agree on it
  function automatic logic [3:0] debounce(input int n, input logic [3:0] held);
    int last;
    if (hist.size() < n) return held;
    last = hist[hist.size()-1];
    for (int i = hist.size() - n; i < hist.size(); i++)
      if (hist[i] != last) return held;
    return 4'(last);
  endfunction

  task automatic model_frame(output logic [3:0] c, output logic [23:0] a);
    logic [23:0] mx;
    mx = 0;
    for (int k = 1; k <= 11; k++) if (areas[k] > mx) mx = areas[k];
    c = 0;
    if (mx >= AREA_MIN)
      for (int k = 11; k >= 1; k--) if (areas[k] == mx) c = 4'(k);
    a = (c != 0) ? mx : 24'd0;
    hist.push_back(int'(c));
    cls1_m = debounce(1, cls1_m);
    cls3_m = debounce(3, cls3_m);
  endtask

  task automatic watch(input int n, output int nv, output int nb);
    nv = 0;
    nb = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      nv += int'(bus1.o_valid) + int'(bus3.o_valid);
      nb += int'(bus1.o_busy) + int'(bus3.o_busy);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_class"}, {bus1.o_class, bus3.o_class}, 0);
    check({tag, "_cand"}, {bus1.o_cand, bus3.o_cand}, 0);
    check({tag, "_area"}, {8'd0, bus1.o_area | bus3.o_area}, 0);
    check({tag, "_valid_busy"}, {bus1.o_valid, bus3.o_valid, bus1.o_busy, bus3.o_busy}, 0);
  endtask

  // one full frame: i_vs rises at cycle T, result expected exactly at T+15
  task automatic run_frame(input string tag, input bit drop_en);
    logic [3:0]  c;
    logic [23:0] a;
    pack_areas();
    model_frame(c, a);
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk);
      #1;
      if (t == 2)
        for (int w = 0; w < 11; w++) area_bus[24*w +: 24] = 24'($urandom);
      if (t == 6 && drop_en) en = 1'b0;
    end
    check({tag, "_early_valid"}, {bus1.o_valid, bus3.o_valid}, 0);
    check({tag, "_busy"}, {bus1.o_busy, bus3.o_busy}, 2'b11);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {bus1.o_valid, bus3.o_valid}, 2'b11);
    check({tag, "_cand1"}, bus1.o_cand, c);
    check({tag, "_area1"}, bus1.o_area, a);
    check({tag, "_class1"}, bus1.o_class, cls1_m);
    check({tag, "_cand3"}, bus3.o_cand, c);
    check({tag, "_area3"}, bus3.o_area, a);
    check({tag, "_class3"}, bus3.o_class, cls3_m);
    $display("frame %s cand=%0d area=%0d class1=%0d class3=%0d",
             tag, bus1.o_cand, bus1.o_area, bus1.o_class, bus3.o_class);
    @(negedge clk);
    vs = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, {bus1.o_valid, bus3.o_valid, bus1.o_busy, bus3.o_busy}, 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int nv, nb;
    logic [3:0]  c;
    logic [23:0] a;
    rst_n    = 1'b0;
    en       = 1'b1;
    vs       = 1'b0;
    area_bus = '0;
    cls1_m   = 0;
    cls3_m   = 0;
    set_all(24'd0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_released");

    set_all(24'd100);
    areas[5] = 24'd5000;
    run_frame("single_c5", 1'b0);

    set_all(24'd0);
    areas[3] = 24'd8000;
    areas[7] = 24'd8000;
    run_frame("tie_3_7", 1'b0);

    set_all(24'd10);
    areas[2] = 24'd1999;
    run_frame("thresh_1999", 1'b0);
    areas[2] = 24'd2000;
    run_frame("thresh_2000", 1'b0);

    set_all(24'd0);
    areas[11] = 24'hFFFFFF;
    areas[1]  = 24'h7FFFFF;
    run_frame("msb_compare", 1'b0);

    for (int f = 0; f < 16; f++) begin
      for (int k = 1; k <= 11; k++) begin
        case ($urandom_range(0, 4))
          0: areas[k] = 24'($urandom_range(0, 2500));
          1: areas[k] = 24'd2000;
          2: areas[k] = 24'd1999;
          3: areas[k] = 24'd3000;
          default: areas[k] = 24'($urandom_range(0, 24'hFFFFFF));
        endcase
      end
      run_frame($sformatf("rand%0d", f), 1'b0);
    end

    // second sync edge while busy is dropped
    set_all(24'd50);
    areas[8] = 24'd9000;
    pack_areas();
    model_frame(c, a);
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vs = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vs = 1'b1;
    watch(25, nv, nb);
    check("busy_single_pulse", nv, 2);
    check("busy_cand", bus1.o_cand, c);
    $display("busy_ignore valids=%0d cand=%0d", nv, bus1.o_cand);
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(posedge clk);

    // disabled at the frame edge
    en = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    watch(25, nv, nb);
    check("en0_valid", nv, 0);
    check("en0_busy", nb, 0);
    $display("en_low valids=%0d busy_cycles=%0d", nv, nb);
    @(negedge clk);
    vs = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);

    set_all(24'd2100);
    areas[6] = 24'd4000;
    run_frame("en_drop", 1'b1);

    // reset in the middle of SCAN, with i_vs still high at release
    set_all(24'd7000);
    pack_areas();
    @(negedge clk);
    vs = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    watch(3, nv, nb);
    check("reset_mid_no_valid", nv, 0);
    hist.delete();
    cls1_m = 0;
    cls3_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    watch(20, nv, nb);
    check("vs_high_release_valid", nv, 0);
    check("vs_high_release_busy", nb, 0);
    $display("reset_mid valids=%0d busy_cycles=%0d", nv, nb);
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(posedge clk);

    set_all(24'd0);
    areas[9] = 24'd6000;
    run_frame("after_reset", 1'b0);

    foreach (hist[i]) begin end
    for (int f = 0; f < 6; f++) begin
      set_all(24'd300);
      if (f == 2) areas[6] = 24'd5000;
      else        areas[4] = 24'd5000;
      run_frame($sformatf("debounce%0d", f), 1'b0);
      if (f < 5) check($sformatf("debounce%0d_hold", f), bus3.o_class, 0);
      else       check("debounce_final", bus3.o_class, 4);
    end

    set_all(24'd0);
    for (int f = 0; f < 3; f++) run_frame($sformatf("zero%0d", f), 1'b0);
    check("zero_debounced", {bus1.o_class, bus3.o_class}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fruit_classify.md
FRUIT_CLASSIFY -- requirements
Module: fruit_classify

Interface
REQ-001 Parameter AREA_MIN, default 24'd2000: minimum winning pixel area for a fruit to be declared.
REQ-002 Parameter STABLE_N, default 3: consecutive identical per-frame candidates required before o_class changes.
REQ-003 pixelclk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  enables classification; when low, new frame ends are ignored.
REQ-006 i_vs  input  1  vertical sync from the per-colour area counters, active high.
REQ-007 i_area  input  264  packed per-class areas: class k (1..11) at bits [24k-1:24(k-1)], unsigned.
REQ-008 o_class  output  4  debounced fruit class, 0 = none, 1..11 = colour class index.
REQ-009 o_area  output  24  area of this frame's winning class; 0 when no candidate.
REQ-010 o_cand  output  4  this frame's raw, undebounced candidate.
REQ-011 o_valid  output  1  one-cycle pulse per completed classification.
REQ-012 o_busy  output  1  high while the state machine is not IDLE.

Function
REQ-013 i_vs SHALL be registered once; frame end = rising edge of that registered copy (cycle T = first clock sampling i_vs high, edge seen at T+1).
REQ-014 FSM states: IDLE, SNAP, SCAN, DECIDE, UPDATE; encoding is free.
REQ-015 IDLE -> SNAP on a detected frame end with en=1; otherwise stay in IDLE.
REQ-016 SNAP: copy all 264 bits of i_area into an internal snapshot; clear max=0, idx=0, k=1.
REQ-017 SCAN: one class per cycle, k=1..11 (11 cycles).
REQ-018 In SCAN, when area[k] > max (strictly greater), load max=area[k] and idx=k; ties keep the lower index.
REQ-019 After k=11, go to DECIDE.
REQ-020 DECIDE: cand = (max >= AREA_MIN) ? idx : 0; o_area = (cand != 0) ? max : 0.
REQ-021 UPDATE, same-candidate case: if cand == prev_cand, stable_cnt += 1, saturating at STABLE_N.
REQ-022 UPDATE, new-candidate case: if cand != prev_cand, prev_cand = cand and stable_cnt = 1.
REQ-023 o_class SHALL load cand in the UPDATE cycle in which the updated stable_cnt equals STABLE_N; otherwise o_class holds.
REQ-024 o_cand SHALL update in UPDATE; o_valid SHALL be high for exactly the UPDATE cycle; then return to IDLE.
REQ-025 Latency: o_valid high at cycle T+15 (edge T+1, SNAP T+2, SCAN T+3..T+13, DECIDE T+14, UPDATE T+15).
REQ-026 Frame-end edges arriving while o_busy=1 SHALL be ignored and not queued.
REQ-027 en falling mid-operation SHALL NOT abort; the current frame completes and pulses o_valid.
REQ-028 i_area changes after SNAP SHALL NOT affect the result.
REQ-029 All-zero areas SHALL give cand=0 and o_area=0; that result debounces like any class.
REQ-030 With STABLE_N=1, o_class SHALL follow cand every frame.
REQ-031 stable_cnt width SHALL hold STABLE_N without overflow; max comparison SHALL be full 24-bit unsigned.

Reset
REQ-032 On rst_n low: FSM to IDLE; o_class, o_area, o_cand, prev_cand, stable_cnt, snapshot and max all 0; o_valid=0, o_busy=0; registered i_vs = 0.
REQ-033 Reset asserted mid-SCAN SHALL abort with no o_valid pulse.
REQ-034 If i_vs is high at reset release, no frame end SHALL be detected until i_vs goes low, then high.

Verification
REQ-035 Single frame: class 5 = 5000, all others 100, en=1, STABLE_N=1, i_vs rises -> o_valid at T+15, o_cand=5, o_area=5000, o_class=5.
REQ-036 Tie: classes 3 and 7 both 8000, the rest 0 -> o_cand=3, o_area=8000.
REQ-037 Threshold: max area 1999 (class 2) -> o_cand=0, o_area=0; repeat with 2000 -> o_cand=2.
REQ-038 Debounce: STABLE_N=3; candidates over successive frames 4,4,6,4,4,4 -> o_class stays 0 until the sixth o_valid, then becomes 4.
REQ-039 Busy/enable: second i_vs edge 5 clocks after the first -> single o_valid pulse. en=0 at an edge -> no o_busy, no o_valid. en dropped during SCAN -> o_valid still pulses.
REQ-040 Reset: assert rst_n low at T+8 of a frame -> all outputs 0 immediately, no o_valid. Next frame after release classifies normally.
